// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction constants and Gray encoding helper for counter_mod_n
package counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Width-generic by working at 32 bits; callers truncate, which keeps the top Gray bit correct
  // because the zero-extended bit above it is 0.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/reg_vec.sv
// rtl/reg_vec.sv - WIDTH-bit register with async active-low reset to a parameterised value
module reg_vec #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/counter_mod_n.sv
// rtl/counter_mod_n.sv - modulo-N up/down counter with clear, load and cascade tc; COUNTER_MOD_N_GRAY_EN selects Gray output
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             load_err
);

  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
      RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_err
    $error("counter_mod_n: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             err_nxt;

  reg_vec #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_CNT)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .d   (cnt_nxt),
    .q   (cnt)
  );

  // Explicit wrap compares so non-power-of-two moduli never rely on overflow.
  always_comb begin
    cnt_nxt = cnt;
    err_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      if (load_val <= MAX_CNT) begin
        cnt_nxt = load_val;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (up_dn == CNT_UP) begin
        cnt_nxt = (cnt == MAX_CNT) ? '0 : cnt + WIDTH'(1);
      end else begin
        cnt_nxt = (cnt == '0) ? MAX_CNT : cnt - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_err <= 1'b0;
    end else begin
      load_err <= err_nxt;
    end
  end

  assign tc = en & ((up_dn == CNT_UP) ? (cnt == MAX_CNT) : (cnt == '0));

`ifdef COUNTER_MOD_N_GRAY_EN
  assign out = WIDTH'(bin2gray(32'(cnt)));
`else
  assign out = cnt;
`endif

endmodule

// File: tb/tb_counter_mod_n.sv
// tb/tb_counter_mod_n.sv - directed self-checking bench for counter_mod_n (default and MODULUS=6 instances)
module tb_counter_mod_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_en, d_up, d_clr, d_load;
  logic [2:0] d_val, d_out;
  logic       d_tc, d_err;
  logic       m_en, m_up, m_clr, m_load;
  logic [2:0] m_val, m_out;
  logic       m_tc, m_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  counter_mod_n u_dflt (
    .clk (clk), .rst (rst), .en (d_en), .up_dn (d_up), .clr (d_clr),
    .load (d_load), .load_val (d_val), .out (d_out), .tc (d_tc), .load_err (d_err)
  );

  counter_mod_n #(.WIDTH(3), .MODULUS(6), .RESET_VAL(0)) u_mod6 (
    .clk (clk), .rst (rst), .en (m_en), .up_dn (m_up), .clr (m_clr),
    .load (m_load), .load_val (m_val), .out (m_out), .tc (m_tc), .load_err (m_err)
  );

  function automatic logic [2:0] enc(input logic [2:0] v);
`ifdef COUNTER_MOD_N_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; waiting for the next one lets exactly one rising edge pass.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] prev;
    logic [2:0] exp_m [4] = '{3'd1, 3'd0, 3'd5, 3'd4};
    rst = 1'b0;
    {d_en, d_up, d_clr, d_load, d_val} = '0;
    {m_en, m_up, m_clr, m_load, m_val} = '0;
    #1;
    check("rst_out", d_out, enc(3'd0));
    check("rst_err", d_err, 0);
    check("rst_tc_idle", d_tc, 0);
    d_en = 1'b1; d_up = 1'b0;
    #1;
    check("rst_tc_dn", d_tc, 1);
    d_up = 1'b1;
    #1;
    check("rst_tc_up", d_tc, 0);

    // 1: default mod-8 up count with wrap
    tick();
    rst = 1'b1;
    check("t1_start", d_out, enc(3'd0));
    prev = d_out;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("t1_out%0d", i), d_out, enc(3'(i % 8)));
      check($sformatf("t1_tc%0d", i), d_tc, ((i % 8) == 7) ? 1 : 0);
`ifdef COUNTER_MOD_N_GRAY_EN
      check($sformatf("t1_gray_flip%0d", i), $countones(prev ^ d_out), 1);
`endif
      prev = d_out;
    end
    d_en = 1'b0;

    // 2: mod-6 down count after load
    m_up = 1'b0; m_load = 1'b1; m_val = 3'd2;
    tick();
    m_load = 1'b0; m_en = 1'b1;
    check("t2_load", m_out, enc(3'd2));
    check("t2_tc2", m_tc, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t2_out%0d", i), m_out, enc(exp_m[i]));
      check($sformatf("t2_tc%0d", i), m_tc, (exp_m[i] == 3'd0) ? 1 : 0);
    end
    m_en = 1'b0;

    // 3: out-of-range loads
    m_load = 1'b1; m_val = 3'd7;
    tick();
    check("t3_hold7", m_out, enc(3'd4));
    check("t3_err7", m_err, 1);
    m_load = 1'b0;
    tick();
    check("t3_err_pulse", m_err, 0);
    m_load = 1'b1; m_val = 3'd6;
    tick();
    check("t3_hold6", m_out, enc(3'd4));
    check("t3_err6", m_err, 1);
    m_val = 3'd5;
    tick();
    check("t3_load5", m_out, enc(3'd5));
    check("t3_err5", m_err, 0);
    m_load = 1'b0; m_en = 1'b1; m_up = 1'b1;
    #1;
    check("t3_tc_up5", m_tc, 1);
    tick();
    check("t3_wrap_up", m_out, enc(3'd0));
    m_en = 1'b0;

    // 4: priority clr > load > en
    d_load = 1'b1; d_val = 3'd4;
    tick();
    check("t4_load4", d_out, enc(3'd4));
    d_clr = 1'b1; d_en = 1'b1; d_val = 3'd6;
    tick();
    check("t4_clr", d_out, enc(3'd0));
    check("t4_clr_err", d_err, 0);
    d_clr = 1'b0; d_val = 3'd3;
    tick();
    check("t4_load_beats_en", d_out, enc(3'd3));
    d_load = 1'b0;
    tick();
    check("t4_count4", d_out, enc(3'd4));

    // 5: asynchronous reset mid-cycle, with a pending load_err on the mod-6 instance
    m_load = 1'b1; m_val = 3'd7;
    @(posedge clk);
    #2;
    check("t5_count5", d_out, enc(3'd5));
    check("t5_err_set", m_err, 1);
    rst = 1'b0;
    #1;
    check("t5_async_out", d_out, enc(3'd0));
    check("t5_async_err", m_err, 0);
    check("t5_async_m_out", m_out, enc(3'd0));
    m_load = 1'b0;
    tick();
    tick();
    check("t5_hold_low", d_out, enc(3'd0));
    rst = 1'b1;
    check("t5_release", d_out, enc(3'd0));
    tick();
    check("t5_resume", d_out, enc(3'd1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
